pll_cfg_shadow: RTL and testbench



---
 rtl/pll_cfg_pkg.sv | 41 ++++
 rtl/pll_cfg_shadow_if.sv | 30 +++
 rtl/pll_cfg_timer.sv | 35 +++
 rtl/pll_cfg_shadow.sv | 191 +++++++++++++++++++
 tb/tb_pll_cfg_shadow.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_pkg.sv
// ============================================================================
// Module   : pll_cfg_pkg
// Brief    : Shared register map, state encoding and register-set type for
//            the PLL configuration shadow target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_cfg_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_MODE   = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'd1;
  localparam logic [ADDR_W-1:0] ADDR_START  = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_N      = 6'd3;
  localparam logic [ADDR_W-1:0] ADDR_M      = 6'd4;
  localparam logic [ADDR_W-1:0] ADDR_C0     = 6'd5;
  localparam logic [ADDR_W-1:0] ADDR_K      = 6'd7;
  localparam logic [ADDR_W-1:0] ADDR_BW     = 6'd8;
  localparam logic [ADDR_W-1:0] ADDR_CP     = 6'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    RELOCK = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] c0;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] bw;
    logic [DATA_W-1:0] cp;
  } cfg_regs_t;

endpackage

`default_nettype wire

// File: rtl/pll_cfg_shadow_if.sv
// ============================================================================
// Module   : pll_cfg_shadow_if
// Brief    : Avalon-MM management bus bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pll_cfg_shadow_if;

  logic [pll_cfg_pkg::ADDR_W-1:0] mgmt_address;
  logic                           mgmt_write;
  logic [pll_cfg_pkg::DATA_W-1:0] mgmt_writedata;
  logic                           mgmt_read;
  logic [pll_cfg_pkg::DATA_W-1:0] mgmt_readdata;
  logic                           mgmt_readdatavalid;
  logic                           mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    input  mgmt_readdata, mgmt_readdatavalid, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    output mgmt_readdata, mgmt_readdatavalid, mgmt_waitrequest
  );

endinterface

`default_nettype wire

// File: rtl/pll_cfg_timer.sv
// ============================================================================
// Module   : pll_cfg_timer
// Brief    : Loadable down-counter that parks at zero and flags it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_cfg_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_50M,
  input  logic             RESET,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pll_cfg_shadow.sv
// ============================================================================
// Module   : pll_cfg_shadow
// Brief    : Behavioural PLL reconfiguration target: staging/active registers
//            and a timed apply-then-relock sequence. Readback path is built
//            only when PLL_CFG_SHADOW_READ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_cfg_shadow
  import pll_cfg_pkg::*;
#(
  parameter int APPLY_CYCLES = 64,
  parameter int LOCK_CYCLES  = 256
) (
  input  logic                   CLK_50M,
  input  logic                   RESET,
  input  logic                   pll_rst,
  pll_cfg_shadow_if.slave        mgmt,
  output logic                   pll_locked,
  output logic [DATA_W-1:0]      active_m,
  output logic [DATA_W-1:0]      active_k,
  output logic [DATA_W-1:0]      active_c0,
  output logic [15:0]            apply_count,
  output logic                   status_overrun
);

  localparam int CNT_MAX = (APPLY_CYCLES > LOCK_CYCLES) ? APPLY_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] APPLY_RELOAD = CNT_W'(APPLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_RELOAD  = CNT_W'(LOCK_CYCLES - 1);

  state_t           state_q, state_d;
  cfg_regs_t        stage_q, active_q;
  logic             mode_q, overrun_q, pending_q;
  logic [15:0]      apply_count_q;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             waitreq, wr_acc, wr_start, start_go, done_evt, overrun_set;

  assign waitreq  = (state_q == APPLY) && !mode_q;
  assign wr_acc   = mgmt.mgmt_write && !waitreq;
  assign wr_start = wr_acc && (mgmt.mgmt_address == ADDR_START);

  pll_cfg_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (LOCK_RELOAD)
  ) u_timer (
    .CLK_50M    (CLK_50M),
    .RESET      (RESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CLK_50M) begin
    if (RESET) state_q <= RELOCK;
    else       state_q <= state_d;
  end

  // External PLL reset outranks everything and keeps the lock timer reloaded.
  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_val     = LOCK_RELOAD;
    start_go    = 1'b0;
    done_evt    = 1'b0;
    overrun_set = wr_start && (state_q != IDLE);
    if (pll_rst) begin
      state_d  = RELOCK;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_start) begin
            state_d  = APPLY;
            tmr_load = 1'b1;
            tmr_val  = APPLY_RELOAD;
            start_go = 1'b1;
          end
        end
        APPLY: begin
          if (tmr_zero) begin
            state_d  = RELOCK;
            tmr_load = 1'b1;
          end
        end
        RELOCK: begin
          if (tmr_zero) begin
            state_d  = IDLE;
            done_evt = 1'b1;
          end
        end
        default: begin
          state_d  = RELOCK;
          tmr_load = 1'b1;
        end
      endcase
    end
  end

  // pending_q keeps power-up and pll_rst-only relocks out of apply_count.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      stage_q       <= '0;
      active_q      <= '0;
      mode_q        <= 1'b0;
      overrun_q     <= 1'b0;
      pending_q     <= 1'b0;
      apply_count_q <= '0;
    end else begin
      if (start_go) begin
        active_q  <= stage_q;
        pending_q <= 1'b1;
      end
      if (done_evt && pending_q) begin
        apply_count_q <= apply_count_q + 16'd1;
        pending_q     <= 1'b0;
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (wr_acc && (mgmt.mgmt_address == ADDR_STATUS)) begin
        overrun_q <= 1'b0;
      end
      if (wr_acc) begin
        case (mgmt.mgmt_address)
          ADDR_MODE: mode_q     <= mgmt.mgmt_writedata[0];
          ADDR_N:    stage_q.n  <= mgmt.mgmt_writedata;
          ADDR_M:    stage_q.m  <= mgmt.mgmt_writedata;
          ADDR_C0:   stage_q.c0 <= mgmt.mgmt_writedata;
          ADDR_K:    stage_q.k  <= mgmt.mgmt_writedata;
          ADDR_BW:   stage_q.bw <= mgmt.mgmt_writedata;
          ADDR_CP:   stage_q.cp <= mgmt.mgmt_writedata;
          default: ;
        endcase
      end
    end
  end

`ifdef PLL_CFG_SHADOW_READ_EN
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rd_acc;

  // A read that coincides with a write is dropped.
  assign rd_acc = mgmt.mgmt_read && !mgmt.mgmt_write && !waitreq;

  always_comb begin
    rdata_d = '0;
    case (mgmt.mgmt_address)
      ADDR_MODE:   rdata_d = {31'd0, mode_q};
      ADDR_STATUS: rdata_d = {30'd0, overrun_q, (state_q == IDLE)};
      ADDR_N:      rdata_d = stage_q.n;
      ADDR_M:      rdata_d = stage_q.m;
      ADDR_C0:     rdata_d = stage_q.c0;
      ADDR_K:      rdata_d = stage_q.k;
      ADDR_BW:     rdata_d = stage_q.bw;
      ADDR_CP:     rdata_d = stage_q.cp;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rdata_d;
    end
  end

  assign mgmt.mgmt_readdata      = rdata_q;
  assign mgmt.mgmt_readdatavalid = rvalid_q;
`else
  logic unused_read;
  assign unused_read             = mgmt.mgmt_read;
  assign mgmt.mgmt_readdata      = '0;
  assign mgmt.mgmt_readdatavalid = 1'b0;
`endif

  assign mgmt.mgmt_waitrequest = waitreq;
  assign pll_locked            = (state_q == IDLE);
  assign active_m              = active_q.m;
  assign active_k              = active_q.k;
  assign active_c0             = active_q.c0;
  assign apply_count           = apply_count_q;
  assign status_overrun        = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_shadow.sv
// ============================================================================
// Module   : tb_pll_cfg_shadow
// Brief    : Directed plus randomized bench for pll_cfg_shadow against a
//            cycle-number based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_cfg_shadow;

  localparam int A = 64;
  localparam int L = 256;
`ifdef PLL_CFG_SHADOW_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        CLK_50M = 1'b0;
  logic        RESET   = 1'b1;
  logic        pll_rst = 1'b0;
  logic        pll_locked;
  logic [31:0] active_m, active_k, active_c0;
  logic [15:0] apply_count;
  logic        status_overrun;

  pll_cfg_shadow_if bus();

  pll_cfg_shadow #(.APPLY_CYCLES(A), .LOCK_CYCLES(L)) dut (
    .CLK_50M        (CLK_50M),
    .RESET          (RESET),
    .pll_rst        (pll_rst),
    .mgmt           (bus),
    .pll_locked     (pll_locked),
    .active_m       (active_m),
    .active_k       (active_k),
    .active_c0      (active_c0),
    .apply_count    (apply_count),
    .status_overrun (status_overrun)
  );

  always #10 CLK_50M = ~CLK_50M;

  int checks = 0;
  int errors = 0;

  // Reference model: time is the number of rising edges seen so far; the
  // cycle following edge c is labelled c.
  int          cyc = 0;
  int          lock_from = 0;
  int          wait_start = 0;
  int          wait_end = 0;
  int          rv_edge = -1;
  int          m_count = 0;
  bit          m_pending = 0;
  bit          m_mode = 0;
  bit          m_ovr = 0;
  logic [31:0] m_stg [0:63];
  logic [31:0] m_am = 0, m_ak = 0, m_ac0 = 0, m_rdata = 0;
  logic [5:0]  alist [10] = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd12, 6'd40};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_wait(input int c);
    return !m_mode && (c >= wait_start) && (c < wait_end);
  endfunction

  function automatic logic [31:0] rd_model(input logic [5:0] a, input bit idle);
    case (a)
      6'd0:                                  return {31'd0, m_mode};
      6'd1:                                  return {30'd0, m_ovr, idle};
      6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9:    return m_stg[a];
      default:                               return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_stg[i] = 32'd0;
    m_mode = 0; m_ovr = 0; m_pending = 0; m_count = 0;
    m_am = 0; m_ak = 0; m_ac0 = 0; m_rdata = 0; rv_edge = -1;
    lock_from = cyc + L; wait_start = 0; wait_end = 0;
  endtask

  // One clock edge: sample the driven bus, advance the model, then compare.
  task automatic step();
    logic       rst_s, prst_s, w_s, r_s;
    logic [5:0] a_s;
    logic [31:0] d_s;
    bit         acc, idle_prev;
    rst_s = RESET; prst_s = pll_rst; w_s = bus.mgmt_write; r_s = bus.mgmt_read;
    a_s = bus.mgmt_address; d_s = bus.mgmt_writedata;
    acc = !exp_wait(cyc);
    idle_prev = (cyc >= lock_from);
    @(posedge CLK_50M);
    cyc++;
    if (rst_s) begin
      model_reset();
    end else begin
      if (READ_EN && acc && r_s && !w_s) begin
        m_rdata = rd_model(a_s, idle_prev);
        rv_edge = cyc;
      end
      if (acc && w_s) begin
        case (a_s)
          6'd0: m_mode = d_s[0];
          6'd1: m_ovr = 0;
          6'd2: begin
            if (!idle_prev) begin
              m_ovr = 1;
            end else if (!prst_s) begin
              m_am = m_stg[4]; m_ak = m_stg[7]; m_ac0 = m_stg[5];
              m_pending = 1;
              wait_start = cyc; wait_end = cyc + A; lock_from = cyc + A + L;
            end
          end
          6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9: m_stg[a_s] = d_s;
          default: ;
        endcase
      end
      if (prst_s) begin
        lock_from = cyc + L;
        wait_end  = cyc;
      end
      if (m_pending && cyc == lock_from) begin
        m_count = (m_count + 1) & 16'hFFFF;
        m_pending = 0;
      end
    end
    #1;
    chk("locked", 32'(pll_locked), 32'(cyc >= lock_from));
    chk("waitreq", 32'(bus.mgmt_waitrequest), 32'(exp_wait(cyc)));
    chk("apply_count", 32'(apply_count), 32'(m_count));
    chk("overrun", 32'(status_overrun), 32'(m_ovr));
    chk("active_m", active_m, m_am);
    chk("active_k", active_k, m_ak);
    chk("active_c0", active_c0, m_ac0);
    chk("rvalid", 32'(bus.mgmt_readdatavalid), 32'(rv_edge == cyc));
    chk("rdata", bus.mgmt_readdata, m_rdata);
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input bit with_rd);
    int n = 0;
    bus.mgmt_address = a; bus.mgmt_writedata = d;
    bus.mgmt_write = 1'b1; bus.mgmt_read = with_rd;
    while (exp_wait(cyc) && n < 4 * A) begin step(); n++; end
    step();
    bus.mgmt_write = 1'b0; bus.mgmt_read = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a);
    int n = 0;
    bus.mgmt_address = a; bus.mgmt_read = 1'b1;
    while (exp_wait(cyc) && n < 4 * A) begin step(); n++; end
    step();
    bus.mgmt_read = 1'b0;
  endtask

  task automatic wait_locked(input string tag);
    int n = 0;
    while (!pll_locked && n < 4 * (A + L)) begin step(); n++; end
    chk(tag, 32'(pll_locked), 32'd1);
  endtask

  initial begin
    int t0, n;
    bus.mgmt_address = '0; bus.mgmt_writedata = '0;
    bus.mgmt_write = 1'b0; bus.mgmt_read = 1'b0;

    // Reset and power-up relock
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    for (int i = 1; i < L; i++) step();
    chk("lock_before_256", 32'(pll_locked), 32'd0);
    step();
    chk("lock_at_256", 32'(pll_locked), 32'd1);
    chk("count_after_reset", 32'(apply_count), 32'd0);
    bus_rd(6'd1);
    chk("status_idle", bus.mgmt_readdata, READ_EN ? 32'h1 : 32'h0);

    // Waitrequest-mode apply
    bus_wr(6'd4, 32'h0000_0404, 1'b0);
    bus_wr(6'd7, 32'hB333_32DD, 1'b0);
    bus_wr(6'd5, 32'h0002_0201, 1'b0);
    bus_wr(6'd2, 32'h0, 1'b0);
    t0 = cyc;
    n = 0;
    while (bus.mgmt_waitrequest && n < 4 * A) begin step(); n++; end
    chk("waitreq_len", 32'(n), 32'(A));
    wait_locked("lock_after_apply");
    chk("lock_latency", 32'(cyc - t0), 32'(A + L));
    chk("active_m_applied", active_m, 32'h0000_0404);
    chk("active_k_applied", active_k, 32'hB333_32DD);
    chk("count_one", 32'(apply_count), 32'd1);

    // Polling mode: writes while busy, overrun and its clear
    bus_wr(6'd0, 32'h1, 1'b0);
    bus_wr(6'd2, 32'h0, 1'b0);
    t0 = cyc;
    repeat (5) step();
    chk("poll_no_waitreq", 32'(bus.mgmt_waitrequest), 32'd0);
    bus_wr(6'd4, 32'h167, 1'b0);
    chk("active_m_unchanged", active_m, 32'h0000_0404);
    bus_rd(6'd4);
    chk("staging_m_readback", bus.mgmt_readdata, READ_EN ? 32'h167 : 32'h0);
    while (cyc < t0 + A + 5) step();
    bus_wr(6'd2, 32'h0, 1'b0);
    chk("overrun_set", 32'(status_overrun), 32'd1);
    bus_rd(6'd1);
    chk("status_overrun_rd", bus.mgmt_readdata, READ_EN ? 32'h2 : 32'h0);
    bus_wr(6'd1, 32'hDEAD_BEEF, 1'b0);
    chk("overrun_cleared", 32'(status_overrun), 32'd0);
    wait_locked("lock_after_poll");

    // Unmapped read and read dropped by a simultaneous write
    bus_rd(6'd6);
    chk("rd6_data", bus.mgmt_readdata, 32'h0);
    chk("rd6_valid", 32'(bus.mgmt_readdatavalid), READ_EN ? 32'h1 : 32'h0);
    step();
    chk("rd6_valid_once", 32'(bus.mgmt_readdatavalid), 32'h0);
    bus_wr(6'd8, 32'h55AA_1234, 1'b1);
    chk("rdwr_no_valid", 32'(bus.mgmt_readdatavalid), 32'h0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0:          bus_wr(6'd2, $urandom, 1'b0);
        1:          bus_wr(6'd0, 32'($urandom_range(0, 1)), 1'b0);
        2, 3, 4, 5: bus_wr(alist[$urandom_range(0, 9)], $urandom, 1'($urandom_range(0, 3) == 0));
        6, 7, 8:    bus_rd(alist[$urandom_range(0, 9)]);
        default:    repeat ($urandom_range(1, 40)) step();
      endcase
    end
    wait_locked("lock_after_random");

    // pll_rst pulse mid-relock
    bus_wr(6'd0, 32'h1, 1'b0);
    bus_wr(6'd2, 32'h0, 1'b0);
    repeat (A + 20) step();
    pll_rst = 1'b1;
    repeat (10) step();
    chk("pll_rst_unlocked", 32'(pll_locked), 32'd0);
    pll_rst = 1'b0;
    for (int i = 1; i < L; i++) step();
    chk("relock_before_256", 32'(pll_locked), 32'd0);
    step();
    chk("relock_at_256", 32'(pll_locked), 32'd1);

    // RESET during APPLY
    bus_wr(6'd0, 32'h0, 1'b0);
    bus_wr(6'd4, 32'h0BAD_0F00, 1'b0);
    bus_wr(6'd2, 32'h0, 1'b0);
    repeat (10) step();
    chk("apply_waitreq", 32'(bus.mgmt_waitrequest), 32'd1);
    t0 = apply_count;
    RESET = 1'b1;
    repeat (2) step();
    chk("rst_active_m", active_m, 32'h0);
    chk("rst_count", 32'(apply_count), 32'd0);
    chk("rst_locked", 32'(pll_locked), 32'd0);
    chk("rst_waitreq", 32'(bus.mgmt_waitrequest), 32'd0);
    chk("rst_overrun", 32'(status_overrun), 32'd0);
    chk("rst_rvalid", 32'(bus.mgmt_readdatavalid), 32'd0);
    RESET = 1'b0;
    repeat (L + 5) step();
    chk("no_count_after_abort", 32'(apply_count), 32'd0);
    bus_rd(6'd4);
    chk("staging_cleared", bus.mgmt_readdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
